// File: rtl/beat_note_sequencer_if.sv
// Control and audio signals of the beat-driven note sequencer.
// The sequencer takes the slave side; the driver of beat/start/stop takes the master side.
interface beat_note_sequencer_if;
    logic       beat_clk;
    logic       start;
    logic       stop;
    logic       tone_out;
    logic [3:0] note_index;
    logic [3:0] note_code;
    logic       playing;
    logic       done;

    modport master (
        output beat_clk, start, stop,
        input  tone_out, note_index, note_code, playing, done
    );

    modport slave (
        input  beat_clk, start, stop,
        output tone_out, note_index, note_code, playing, done
    );
endinterface

// File: rtl/beat_note_sequencer.sv
// Steps through a 16-entry note ROM once per rising edge of the slow beat clock
// and renders each note as a 50% duty square wave on tone_out.
module beat_note_sequencer #(
    parameter int SONG_LEN   = 16,
    parameter int TONE_SHIFT = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    beat_note_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] END_CODE   = 4'd15;
    localparam logic [3:0] LAST_INDEX = 4'(SONG_LEN - 1);

    localparam logic [3:0] NOTE_ROM [16] = '{
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
        4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd15
    };

    // Half-periods in clock cycles for C4..C5; entry 0 is the rest slot.
    localparam logic [16:0] HALF_BASE [9] = '{
        17'd0,     17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    logic [16:0] half_table [9];

    for (genvar gi = 0; gi < 9; gi++) begin : g_half
        assign half_table[gi] = HALF_BASE[gi] >> TONE_SHIFT;
    end

    logic        sync1_reg, sync2_reg, prev_reg;
    logic        tick;
    state_t      state_reg, state_next;
    logic [3:0]  index_reg, index_next;
    logic [3:0]  code_reg, code_next;
    logic [16:0] count_reg, count_next;
    logic        tone_reg, tone_next;
    logic        playing_reg, playing_next;
    logic        done_reg, done_next;

    logic [3:0]  index_plus1;
    logic        end_reached;
    logic        note_is_tone;
    logic [16:0] half_cur;
    logic [16:0] half_last;
    logic        tone_active;

    // beat_clk is foreign to this clock: two-flop synchronizer, then rising-edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= bus.beat_clk;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign tick = sync2_reg & ~prev_reg;

    assign index_plus1  = index_reg + 4'd1;
    assign end_reached  = (index_reg == LAST_INDEX) || (NOTE_ROM[index_plus1] == END_CODE);
    assign note_is_tone = (code_reg != 4'd0) && (code_reg <= 4'd8);
    assign half_cur     = note_is_tone ? half_table[code_reg] : 17'd0;
    assign half_last    = half_cur - 17'd1;
    assign tone_active  = note_is_tone && (half_cur != 17'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // stop beats start, and either one masks a beat tick in the same cycle.
    always_comb begin
        state_next = state_reg;
        if (bus.stop) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (tick && end_reached) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        index_next   = index_reg;
        code_next    = code_reg;
        count_next   = 17'd0;
        tone_next    = 1'b0;
        playing_next = (state_next == PLAY);
        done_next    = (state_next == DONE);

        if (bus.stop) begin
            index_next = 4'd0;
            code_next  = 4'd0;
        end else if (bus.start && (state_reg != PLAY)) begin
            index_next = 4'd0;
            code_next  = NOTE_ROM[0];
        end else if (state_reg == PLAY) begin
            if (tick) begin
                if (end_reached) begin
                    code_next = 4'd0;
                end else begin
                    index_next = index_plus1;
                    code_next  = NOTE_ROM[index_plus1];
                end
            end else if (tone_active) begin
                // Counter restarts on every note change, so the first toggle lands H cycles in.
                if (count_reg == half_last) begin
                    tone_next = ~tone_reg;
                end else begin
                    count_next = count_reg + 17'd1;
                    tone_next  = tone_reg;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index_reg   <= 4'd0;
            code_reg    <= 4'd0;
            count_reg   <= 17'd0;
            tone_reg    <= 1'b0;
            playing_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            index_reg   <= index_next;
            code_reg    <= code_next;
            count_reg   <= count_next;
            tone_reg    <= tone_next;
            playing_reg <= playing_next;
            done_reg    <= done_next;
        end
    end

    assign bus.tone_out   = tone_reg;
    assign bus.note_index = index_reg;
    assign bus.note_code  = code_reg;
    assign bus.playing    = playing_reg;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_beat_note_sequencer.sv
// Self-checking bench for beat_note_sequencer: directed scenarios plus randomized
// beats and button pulses against an event-level reference model.
module tb_beat_note_sequencer;
    localparam int SONG_LEN   = 16;
    localparam int TONE_SHIFT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    beat_note_sequencer_if bus_if();

    beat_note_sequencer #(
        .SONG_LEN   (SONG_LEN),
        .TONE_SHIFT (TONE_SHIFT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: song table, nominal half-periods, and the note timeline.
    int song [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 8, 7, 6, 5, 4, 3, 15};
    int base_half [9] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

    int   cyc = 0;
    int   m_mode = 0;
    int   m_idx = 0;
    int   m_code = 0;
    int   m_note_cyc = 0;
    bit   m_last_beat = 1'b0;
    int   pend [$];
    logic       exp_tone = 1'b0;
    logic [3:0] exp_idx = 4'd0;
    logic [3:0] exp_code = 4'd0;
    logic       exp_playing = 1'b0;
    logic       exp_done = 1'b0;
    int   mon_bad = 0;

    function automatic int half_of(int code);
        if (code >= 1 && code <= 8) return base_half[code] >> TONE_SHIFT;
        return 0;
    endfunction

    initial begin
        bit rise;
        bit tick;
        int h;
        forever begin
            @(posedge clock or posedge reset);
            cyc++;
            if (reset) begin
                m_mode = 0;
                m_idx = 0;
                m_code = 0;
                m_last_beat = 1'b0;
                pend.delete();
            end else begin
                rise = bus_if.beat_clk && !m_last_beat;
                m_last_beat = bus_if.beat_clk;
                tick = (pend.size() > 0) && (pend[0] == cyc);
                if (tick) void'(pend.pop_front());
                // A beat rise takes effect on the third clock edge that sees it.
                if (rise) pend.push_back(cyc + 2);
                if (bus_if.stop) begin
                    m_mode = 0;
                    m_idx = 0;
                    m_code = 0;
                end else if (bus_if.start && m_mode != 1) begin
                    m_mode = 1;
                    m_idx = 0;
                    m_code = song[0];
                    m_note_cyc = cyc;
                end else if (tick && m_mode == 1) begin
                    if (m_idx == SONG_LEN - 1 || song[m_idx + 1] == 15) begin
                        m_mode = 2;
                        m_code = 0;
                    end else begin
                        m_idx++;
                        m_code = song[m_idx];
                        m_note_cyc = cyc;
                    end
                end
            end
            h = half_of(m_code);
            exp_tone    = (m_mode == 1 && h > 0) ? ((((cyc - m_note_cyc) / h) % 2) == 1) : 1'b0;
            exp_idx     = 4'(m_idx);
            exp_code    = 4'(m_code);
            exp_playing = (m_mode == 1);
            exp_done    = (m_mode == 2);
        end
    end

    // Cycle-by-cycle agreement with the model; scenarios check this tally per transaction.
    initial forever begin
        @(negedge clock);
        if (bus_if.tone_out !== exp_tone || bus_if.note_index !== exp_idx ||
            bus_if.note_code !== exp_code || bus_if.playing !== exp_playing ||
            bus_if.done !== exp_done)
            mon_bad++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        step(1);
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        int snap;
        reset = 1'b1;
        step(3);
        checks++;
        if ({bus_if.tone_out, bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {bus_if.tone_out, bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done});
        end
        snap = mon_bad;
        bus_if.beat_clk = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(8);
            bus_if.beat_clk = ~bus_if.beat_clk;
        end
        bus_if.beat_clk = 1'b0;
        step(8);
        checks++;
        if ({bus_if.tone_out, bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done} !== 11'd0) begin
            errors++;
            $display("FAIL idle_no_start got %b want 0", {bus_if.tone_out, bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done});
        end
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL idle_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_reset: idle after release with beat toggling");
    endtask

    task automatic test_start_tone();
        int k;
        int snap;
        snap = mon_bad;
        step(4);
        pulse_start();
        checks++;
        if ({bus_if.playing, bus_if.note_code, bus_if.note_index} !== {1'b1, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL start_state got %b want %b", {bus_if.playing, bus_if.note_code, bus_if.note_index}, {1'b1, 4'd1, 4'd0});
        end
        k = 0;
        while (bus_if.tone_out !== 1'b1 && k < 8000) begin step(1); k++; end
        checks++;
        if (k !== 5972) begin
            errors++;
            $display("FAIL first_rise got %0d cycles want 5972", k);
        end
        k = 0;
        while (bus_if.tone_out !== 1'b0 && k < 8000) begin step(1); k++; end
        checks++;
        if (k !== 5972) begin
            errors++;
            $display("FAIL c4_half got %0d cycles want 5972", k);
        end
        bus_if.beat_clk = 1'b1;
        k = 0;
        while (bus_if.note_index !== 4'd1 && k < 20) begin step(1); k++; end
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL beat_latency got %0d edges want 3", k);
        end
        k = 0;
        while (bus_if.tone_out !== 1'b1 && k < 8000) begin step(1); k++; end
        checks++;
        if (k !== 5320) begin
            errors++;
            $display("FAIL d4_half got %0d cycles want 5320", k);
        end
        bus_if.beat_clk = 1'b0;
        step(8);
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL start_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_start_tone: first rise %0d, index %0d", 5972, bus_if.note_index);
    endtask

    task automatic test_rest_and_c5();
        int k;
        int hi_cnt;
        int snap;
        snap = mon_bad;
        for (int b = 2; b <= 8; b++) begin
            bus_if.beat_clk = 1'b1;
            step(8);
            bus_if.beat_clk = 1'b0;
            step(8);
            checks++;
            if (bus_if.note_index !== 4'(b)) begin
                errors++;
                $display("FAIL beat_index got %0d want %0d", bus_if.note_index, b);
            end
        end
        checks++;
        if (bus_if.note_code !== 4'd0) begin
            errors++;
            $display("FAIL rest_code got %0d want 0", bus_if.note_code);
        end
        hi_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (bus_if.tone_out !== 1'b0) hi_cnt++;
        end
        checks++;
        if (hi_cnt !== 0) begin
            errors++;
            $display("FAIL rest_silent got %0d high cycles want 0", hi_cnt);
        end
        bus_if.beat_clk = 1'b1;
        k = 0;
        while (bus_if.note_index !== 4'd9 && k < 20) begin step(1); k++; end
        checks++;
        if (bus_if.note_code !== 4'd8) begin
            errors++;
            $display("FAIL c5_code got %0d want 8", bus_if.note_code);
        end
        k = 0;
        while (bus_if.tone_out !== 1'b1 && k < 8000) begin step(1); k++; end
        checks++;
        if (k !== 2986) begin
            errors++;
            $display("FAIL c5_half got %0d cycles want 2986", k);
        end
        bus_if.beat_clk = 1'b0;
        step(8);
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL rest_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_rest_and_c5: index %0d code %0d", bus_if.note_index, bus_if.note_code);
    endtask

    task automatic test_to_done();
        int k;
        int snap;
        snap = mon_bad;
        for (int b = 10; b <= 14; b++) begin
            bus_if.beat_clk = 1'b1;
            step(8);
            bus_if.beat_clk = 1'b0;
            step(8);
            checks++;
            if (bus_if.note_index !== 4'(b)) begin
                errors++;
                $display("FAIL beat_index got %0d want %0d", bus_if.note_index, b);
            end
        end
        bus_if.beat_clk = 1'b1;
        k = 0;
        while (bus_if.done !== 1'b1 && k < 20) begin step(1); k++; end
        checks++;
        if ({bus_if.done, bus_if.playing, bus_if.note_index, bus_if.tone_out, bus_if.note_code} !== {1'b1, 1'b0, 4'd14, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL done_state got %b want %b", {bus_if.done, bus_if.playing, bus_if.note_index, bus_if.tone_out, bus_if.note_code}, {1'b1, 1'b0, 4'd14, 1'b0, 4'd0});
        end
        bus_if.beat_clk = 1'b0;
        step(8);
        pulse_start();
        checks++;
        if ({bus_if.done, bus_if.playing, bus_if.note_index, bus_if.note_code} !== {1'b0, 1'b1, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL restart_state got %b want %b", {bus_if.done, bus_if.playing, bus_if.note_index, bus_if.note_code}, {1'b0, 1'b1, 4'd0, 4'd1});
        end
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL done_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_to_done: done reached at index 14, restarted");
    endtask

    task automatic test_stop_start();
        int snap;
        snap = mon_bad;
        for (int b = 1; b <= 5; b++) begin
            bus_if.beat_clk = 1'b1;
            step(8);
            bus_if.beat_clk = 1'b0;
            step(8);
        end
        checks++;
        if (bus_if.note_index !== 4'd5) begin
            errors++;
            $display("FAIL pre_stop_index got %0d want 5", bus_if.note_index);
        end
        bus_if.stop = 1'b1;
        bus_if.start = 1'b1;
        step(1);
        bus_if.stop = 1'b0;
        bus_if.start = 1'b0;
        checks++;
        if ({bus_if.playing, bus_if.done, bus_if.note_index, bus_if.tone_out, bus_if.note_code} !== 11'd0) begin
            errors++;
            $display("FAIL stop_wins got %b want 0", {bus_if.playing, bus_if.done, bus_if.note_index, bus_if.tone_out, bus_if.note_code});
        end
        step(20);
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL stop_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_stop_start: idle after simultaneous stop/start");
    endtask

    task automatic test_random();
        int lo;
        int hi;
        int act;
        int snap;
        for (int t = 0; t < 20; t++) begin
            lo  = $urandom_range(4, 120);
            hi  = ($urandom_range(0, 3) == 0) ? $urandom_range(2500, 4000) : $urandom_range(8, 200);
            act = $urandom_range(0, 9);
            snap = mon_bad;
            bus_if.beat_clk = 1'b1;
            step(6);
            if (act < 3) begin
                pulse_start();
            end else if (act == 3) begin
                bus_if.stop = 1'b1;
                step(1);
                bus_if.stop = 1'b0;
            end else if (act == 4) begin
                bus_if.stop = 1'b1;
                bus_if.start = 1'b1;
                step(1);
                bus_if.stop = 1'b0;
                bus_if.start = 1'b0;
            end
            step(hi);
            bus_if.beat_clk = 1'b0;
            step(lo);
            checks++;
            if ({bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done} !== {exp_idx, exp_code, exp_playing, exp_done}) begin
                errors++;
                $display("FAIL rand_state got %b want %b", {bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done}, {exp_idx, exp_code, exp_playing, exp_done});
            end
            checks++;
            if (mon_bad !== snap) begin
                errors++;
                $display("FAIL rand_model got %0d bad cycles want 0", mon_bad - snap);
            end
            $display("txn %0d: act %0d high %0d low %0d -> index %0d code %0d playing %0d done %0d",
                     t, act, hi, lo, bus_if.note_index, bus_if.note_code, bus_if.playing, bus_if.done);
        end
    endtask

    task automatic test_reset_mid_note();
        int k;
        int snap;
        bus_if.stop = 1'b1;
        step(1);
        bus_if.stop = 1'b0;
        step(2);
        pulse_start();
        k = 0;
        while (bus_if.tone_out !== 1'b1 && k < 7000) begin step(1); k++; end
        checks++;
        if (bus_if.tone_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_note_high got %b want 1", bus_if.tone_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.tone_out, bus_if.playing, bus_if.note_index, bus_if.note_code} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got %b want 0", {bus_if.tone_out, bus_if.playing, bus_if.note_index, bus_if.note_code});
        end
        step(3);
        snap = mon_bad;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_if.beat_clk = ~bus_if.beat_clk;
            step(10);
        end
        bus_if.beat_clk = 1'b0;
        step(10);
        checks++;
        if ({bus_if.playing, bus_if.done, bus_if.note_index, bus_if.tone_out} !== 7'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 0", {bus_if.playing, bus_if.done, bus_if.note_index, bus_if.tone_out});
        end
        checks++;
        if (mon_bad !== snap) begin
            errors++;
            $display("FAIL post_reset_model got %0d bad cycles want 0", mon_bad - snap);
        end
        $display("test_reset_mid_note: tone cleared asynchronously, idle after release");
    endtask

    initial begin
        bus_if.beat_clk = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        test_reset();
        test_start_tone();
        test_rest_and_c5();
        test_to_done();
        test_stop_start();
        test_random();
        test_reset_mid_note();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
